// File: rtl/rv_branch_predictor_if.sv
// Fetch/execute port bundle of the branch predictor.
// master = pipeline side, slave = predictor.
interface rv_branch_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] i_bp_pc_if;
  logic            o_bp_taken_if;
  logic [XLEN-1:0] o_bp_target_if;
  logic            i_bp_update_ex;
  logic            i_bp_is_jump_ex;
  logic [XLEN-1:0] i_bp_pc_ex;
  logic            i_bp_taken_ex;
  logic [XLEN-1:0] i_bp_target_ex;
  logic            i_bp_pred_taken_ex;
  logic [XLEN-1:0] i_bp_pred_target_ex;
  logic            o_bp_mispredict_ex;
  logic [XLEN-1:0] o_bp_redirect_pc_ex;
  logic [31:0]     o_bp_mispredict_cnt;

  modport master (
    output i_bp_pc_if,
    input  o_bp_taken_if,
    input  o_bp_target_if,
    output i_bp_update_ex,
    output i_bp_is_jump_ex,
    output i_bp_pc_ex,
    output i_bp_taken_ex,
    output i_bp_target_ex,
    output i_bp_pred_taken_ex,
    output i_bp_pred_target_ex,
    input  o_bp_mispredict_ex,
    input  o_bp_redirect_pc_ex,
    input  o_bp_mispredict_cnt
  );

  modport slave (
    input  i_bp_pc_if,
    output o_bp_taken_if,
    output o_bp_target_if,
    input  i_bp_update_ex,
    input  i_bp_is_jump_ex,
    input  i_bp_pc_ex,
    input  i_bp_taken_ex,
    input  i_bp_target_ex,
    input  i_bp_pred_taken_ex,
    input  i_bp_pred_target_ex,
    output o_bp_mispredict_ex,
    output o_bp_redirect_pc_ex,
    output o_bp_mispredict_cnt
  );
endinterface

// File: rtl/rv_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF lookup,
// EX update and misprediction/redirect reporting.
module rv_branch_predictor #(
  parameter int XLEN       = 32,
  parameter int BP_ENTRIES = 16
) (
  input logic               i_clk,
  input logic               i_rstn,
  rv_branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(BP_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [BP_ENTRIES-1:0] valid;
  logic [1:0]            ctr    [BP_ENTRIES];
  logic [TAG_W-1:0]      tag    [BP_ENTRIES];
  logic [XLEN-1:0]       target [BP_ENTRIES];

  logic [IDX_W-1:0] idx_if;
  logic [IDX_W-1:0] idx_ex;
  logic [TAG_W-1:0] tag_if;
  logic [TAG_W-1:0] tag_ex;
  logic             hit_if;
  logic             hit_ex;
  logic             taken_if;
  logic             act;
  logic             wr;
  logic             ctr_wr;
  logic             mispredict;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nxt;
  logic [31:0]      cnt;

  assign idx_if = bp.i_bp_pc_if[IDX_W+1:2];
  assign tag_if = bp.i_bp_pc_if[XLEN-1:IDX_W+2];
  assign idx_ex = bp.i_bp_pc_ex[IDX_W+1:2];
  assign tag_ex = bp.i_bp_pc_ex[XLEN-1:IDX_W+2];

  // valid clears asynchronously, so lookup is not-taken in reset
  assign hit_if   = valid[idx_if] && (tag[idx_if] == tag_if);
  assign taken_if = hit_if && ctr[idx_if][1];

  assign bp.o_bp_taken_if  = taken_if;
  assign bp.o_bp_target_if = taken_if ? target[idx_if]
                                      : bp.i_bp_pc_if + XLEN'(4);

  assign act     = bp.i_bp_is_jump_ex | bp.i_bp_taken_ex;
  assign hit_ex  = valid[idx_ex] && (tag[idx_ex] == tag_ex);
  assign ctr_cur = ctr[idx_ex];
  assign wr      = bp.i_bp_update_ex && act;
  assign ctr_wr  = bp.i_bp_update_ex && (hit_ex || act);

  always_comb begin
    ctr_nxt = ctr_cur;
    unique case (1'b1)
      !hit_ex:
        ctr_nxt = bp.i_bp_is_jump_ex ? 2'b11 : 2'b10;
      hit_ex && bp.i_bp_is_jump_ex:
        ctr_nxt = 2'b11;
      hit_ex && !bp.i_bp_is_jump_ex && act:
        ctr_nxt = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
      default:
        ctr_nxt = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
    endcase
  end

  assign mispredict = bp.i_bp_update_ex &&
    ((act != bp.i_bp_pred_taken_ex) ||
     (act && (bp.i_bp_target_ex != bp.i_bp_pred_target_ex)));

  assign bp.o_bp_mispredict_ex  = mispredict;
  assign bp.o_bp_redirect_pc_ex = act ? bp.i_bp_target_ex
                                      : bp.i_bp_pc_ex + XLEN'(4);
  assign bp.o_bp_mispredict_cnt = cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid <= '0;
      cnt   <= '0;
      for (int i = 0; i < BP_ENTRIES; i++) begin
        ctr[i] <= 2'b01;
      end
    end else begin
      if (ctr_wr) ctr[idx_ex] <= ctr_nxt;
      if (wr) valid[idx_ex] <= 1'b1;
      if (mispredict) cnt <= cnt + 32'd1;
    end
  end

  // payload is only meaningful behind valid, so it needs no reset
  always_ff @(posedge i_clk) begin
    if (wr) begin
      tag[idx_ex]    <= tag_ex;
      target[idx_ex] <= bp.i_bp_target_ex;
    end
  end
endmodule

// File: tb/tb_rv_branch_predictor.sv
// Directed scoreboard bench for rv_branch_predictor.
// Expectations are queued at drive time, popped at sample time.
module tb_rv_branch_predictor;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rv_branch_predictor_if #(.XLEN(XLEN)) bus ();

  rv_branch_predictor #(
    .XLEN(XLEN),
    .BP_ENTRIES(16)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .bp(bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = '0;

  task automatic push(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed %h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed %h expected %h", e.nm, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.i_bp_update_ex = 1'b0;
  endtask

  task automatic upd(input logic jump, input logic [31:0] pc,
                     input logic tk, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt,
                     input logic exp_mp, input logic [31:0] exp_rd);
    bus.i_bp_update_ex      = 1'b1;
    bus.i_bp_is_jump_ex     = jump;
    bus.i_bp_pc_ex          = pc;
    bus.i_bp_taken_ex       = tk;
    bus.i_bp_target_ex      = tgt;
    bus.i_bp_pred_taken_ex  = pt;
    bus.i_bp_pred_target_ex = ptgt;
    push("mispredict", {31'd0, exp_mp});
    push("redirect", exp_rd);
    if (exp_mp) exp_cnt = exp_cnt + 32'd1;
    #2;
    pop_chk({31'd0, bus.o_bp_mispredict_ex});
    pop_chk(bus.o_bp_redirect_pc_ex);
  endtask

  task automatic look(input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt);
    bus.i_bp_pc_if = pc;
    push("taken_if", {31'd0, tk});
    push("target_if", tgt);
    #1;
    pop_chk({31'd0, bus.o_bp_taken_if});
    pop_chk(bus.o_bp_target_if);
  endtask

  task automatic cnt_chk();
    push("mispredict_cnt", exp_cnt);
    pop_chk(bus.o_bp_mispredict_cnt);
  endtask

  initial begin
    bus.i_bp_pc_if          = '0;
    bus.i_bp_update_ex      = 1'b0;
    bus.i_bp_is_jump_ex     = 1'b0;
    bus.i_bp_pc_ex          = '0;
    bus.i_bp_taken_ex       = 1'b0;
    bus.i_bp_target_ex      = '0;
    bus.i_bp_pred_taken_ex  = 1'b0;
    bus.i_bp_pred_target_ex = '0;

    // reset lookups
    repeat (2) step();
    look(32'h100, 1'b0, 32'h104);
    cnt_chk();
    look(32'hFFFF_FFFC, 1'b0, 32'h0);
    rstn = 1'b1;
    step();
    look(32'hFFFF_FFFC, 1'b0, 32'h0);
    look(32'h100, 1'b0, 32'h104);

    // idle EX with arbitrary fields: no mispredict, no write
    bus.i_bp_is_jump_ex = 1'b1;
    bus.i_bp_pc_ex = 32'h100;
    bus.i_bp_target_ex = 32'h777;
    push("mispredict_idle", 32'd0);
    #1;
    pop_chk({31'd0, bus.o_bp_mispredict_ex});
    step();
    look(32'h100, 1'b0, 32'h104);

    // branch allocate then hit
    upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    step();
    clr();
    look(32'h100, 1'b1, 32'h80);
    cnt_chk();

    // hysteresis: 10 -> 01
    upd(1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    step();
    clr();
    look(32'h100, 1'b0, 32'h104);
    cnt_chk();

    // 01 -> 10 -> 11 -> 11, then 11 -> 10
    for (int i = 0; i < 3; i++) begin
      upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
      step();
    end
    clr();
    look(32'h100, 1'b1, 32'h80);
    upd(1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    step();
    clr();
    look(32'h100, 1'b1, 32'h80);
    cnt_chk();

    // aliasing: 0x140 shares the index of 0x100
    upd(1'b1, 32'h140, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    step();
    clr();
    look(32'h100, 1'b0, 32'h104);
    look(32'h140, 1'b1, 32'h200);
    cnt_chk();

    // wrong target on a hitting jump
    upd(1'b1, 32'h300, 1'b0, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400);
    step();
    upd(1'b1, 32'h300, 1'b0, 32'h500, 1'b1, 32'h400, 1'b1, 32'h500);
    step();
    clr();
    look(32'h300, 1'b1, 32'h500);
    cnt_chk();

    // same-cycle update and lookup: old entry seen
    upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
    step();
    upd(1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    look(32'h100, 1'b1, 32'h80);
    step();
    clr();
    look(32'h100, 1'b0, 32'h104);
    cnt_chk();

    // mid-stream reset, with an update presented during reset
    upd(1'b1, 32'h104, 1'b0, 32'h900, 1'b0, 32'h0, 1'b1, 32'h900);
    step();
    clr();
    look(32'h104, 1'b1, 32'h900);
    cnt_chk();
    bus.i_bp_update_ex      = 1'b1;
    bus.i_bp_is_jump_ex     = 1'b1;
    bus.i_bp_pc_ex          = 32'h108;
    bus.i_bp_taken_ex       = 1'b1;
    bus.i_bp_target_ex      = 32'hA00;
    bus.i_bp_pred_taken_ex  = 1'b0;
    bus.i_bp_pred_target_ex = 32'h0;
    rstn = 1'b0;
    exp_cnt = '0;
    #1;
    cnt_chk();
    look(32'h104, 1'b0, 32'h108);
    step();
    rstn = 1'b1;
    clr();
    step();
    look(32'h108, 1'b0, 32'h10C);
    look(32'h140, 1'b0, 32'h144);
    cnt_chk();

    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_leftover observed %0d expected 0",
               exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rv_branch_predictor.md
# rv_branch_predictor

Fetch-side branch predictor and the counterpart of the EX-stage branch comparator. In IF it looks up the current PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and supplies a predicted next PC. In EX it takes the resolved outcome of each branch or jump, updates the table, and reports a misprediction together with the corrected PC so the pipeline can flush IF/ID and redirect. One entry per index, no bypass between the update and lookup paths.

## Interface
- `XLEN`, from the `rv_configs` macro (32): datapath width.
- `BP_ENTRIES`, 16: BTB entries; must be a power of two, ≥2. `IDX_W` = log2(`BP_ENTRIES`). Tag = pc[XLEN-1:IDX_W+2].
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_bp_pc_if`  in  XLEN  PC being fetched.
- `o_bp_taken_if`  out  1  prediction is taken.
- `o_bp_target_if`  out  XLEN  predicted next PC: the stored target if taken, else `i_bp_pc_if`+4.
- `i_bp_update_ex`  in  1  a non-flushed branch or jump is resolved in EX this cycle.
- `i_bp_is_jump_ex`  in  1  the resolved instruction is JAL/JALR (always taken).
- `i_bp_pc_ex`  in  XLEN  PC of the resolved instruction.
- `i_bp_taken_ex`  in  1  actual outcome from the branch comparator; ignored (treated as 1) when `i_bp_is_jump_ex` is set.
- `i_bp_target_ex`  in  XLEN  actual taken target.
- `i_bp_pred_taken_ex`  in  1  prediction made for this instruction in IF, carried down the pipeline.
- `i_bp_pred_target_ex`  in  XLEN  predicted next PC, carried down the pipeline.
- `o_bp_mispredict_ex`  out  1  flush IF/ID and redirect.
- `o_bp_redirect_pc_ex`  out  XLEN  correct next PC.
- `o_bp_mispredict_cnt`  out  32  running misprediction count.

## Operation
- **Entry contents:** valid bit, tag, target (XLEN), 2-bit counter `ctr`. The index for both paths is pc[IDX_W+1:2].
- **Reset:** every valid bit = 0, every `ctr` = 2'b01, `o_bp_mispredict_cnt` = 0. Tags and targets do not need to be reset.
- **Lookup (combinational):** hit = valid && tag match.
  - `o_bp_taken_if` = hit && `ctr`[1].
  - `o_bp_target_if` = the entry target when taken, else `i_bp_pc_if`+4. The +4 wraps modulo 2^XLEN.
  - While in reset, `o_bp_taken_if` = 0 and `o_bp_target_if` = `i_bp_pc_if`+4.
- **Actual taken:** act = `i_bp_is_jump_ex` | `i_bp_taken_ex`.
- **Update, when `i_bp_update_ex` = 1:**
  - Hit, jump: `ctr` = 11 and target is overwritten.
  - Hit, branch: `ctr` increments (saturating at 11) when act = 1, otherwise decrements (saturating at 00). Target is overwritten only when act = 1.
  - Miss, act = 1: the entry is allocated and overwritten: valid = 1, new tag, target = `i_bp_target_ex`, `ctr` = 11 for a jump or 10 for a branch. The previous occupant is evicted.
  - Miss, act = 0: no write.
- **Mispredict (combinational, gated by `i_bp_update_ex`):**
  - `o_bp_mispredict_ex` = (act != `i_bp_pred_taken_ex`) || (act && `i_bp_target_ex` != `i_bp_pred_target_ex`).
  - `o_bp_redirect_pc_ex` = act ? `i_bp_target_ex` : `i_bp_pc_ex`+4. The value is don't-care when there is no mispredict; drive it with the same expression regardless.
  - `o_bp_mispredict_cnt` increments on every cycle where `o_bp_mispredict_ex` = 1 and wraps from 0xFFFFFFFF to 0.
- With `i_bp_update_ex` = 0, no state changes and `o_bp_mispredict_ex` = 0.

## Timing
- Lookup latency is 0 cycles: outputs are valid in the same cycle from registered table state.
- An update becomes visible to lookup on the cycle after the rising edge on which it is written.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update entry. There is no forwarding.
- The mispredict outputs are valid in the same cycle as `i_bp_update_ex`. The counter output reflects that event one cycle later.
- Asserting `i_rstn` low mid-operation clears state immediately (asynchronously). An update presented in the same cycle as reset is dropped.
- At most one update per cycle, so there is no write-port contention.

## Test plan
- **Reset lookup:** reset, then look up PC 0x100 → `o_bp_taken_if` = 0, `o_bp_target_if` = 0x104. Repeat at PC 0xFFFFFFFC → target 0x00000000 (wrap).
- **Branch allocate then hit:** update pc_ex = 0x100, branch, taken = 1, target = 0x80, pred_taken = 0.
  - Same cycle → `o_bp_mispredict_ex` = 1, redirect = 0x80.
  - Next cycle, lookup 0x100 → taken = 1, target = 0x80, `o_bp_mispredict_cnt` = 1.
- **Counter hysteresis:**
  - From `ctr` = 10, one not-taken update → 01, lookup predicts not taken, redirect = 0x104.
  - Three taken updates → 11, then one not-taken → 10, still predicted taken.
- **Aliasing:** with `BP_ENTRIES` = 16, allocate 0x100 (target 0x80), then taken-jump update at 0x140 (same index, target 0x200).
  - Lookup 0x100 → not taken (tag miss).
  - Lookup 0x140 → taken, target 0x200.
- **Wrong target:** jump at 0x300 with pred_taken = 1, pred_target = 0x400, actual target = 0x500 → mispredict = 1, redirect = 0x500, entry target becomes 0x500.
- **Same-cycle hazard and reset:**
  - Update 0x100 to not-taken while looking up 0x100 → lookup still returns the old (taken) entry.
  - Drop `i_rstn` mid-stream → `o_bp_mispredict_cnt` = 0 and all lookups return not taken immediately.
